fetch_return_predecode: RTL and testbench
=========================================

Name: fetch_return_predecode

Overview:
- Sits directly downstream of the IF stage, between instruction memory and the RR (register-read) stage.
- Tracks every fetch request (mem_rinst, mem_rinst_addr) through a fixed-latency instruction memory and pairs each returned word with its PC.
- Discards wrong-path words whenever any refetch/redirect fires.
- Predecodes each surviving RV32I instruction (register indices, sign-extended immediate, op class) into a registered IF/RR pipeline register.

Parameters:
- MEM_LATENCY, 1: cycles from the cycle a request is visible on mem_rinst/mem_rinst_addr to the cycle its data is valid on inst_rdata; legal range 1..4.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- mem_rinst  input  1  fetch request valid, from IF
- mem_rinst_addr  input  32  fetch request PC, from IF
- inst_rdata  input  32  instruction word from memory, MEM_LATENCY cycles after its request
- do_refetch  input  3  {branch_hit_ex, load_related_rr, branch_hit_rr}; any bit set = redirect this cycle
- rr_valid  output  1  pipeline register holds a valid instruction
- rr_pc  output  32  PC of held instruction
- rr_inst  output  32  raw instruction word
- rr_rs1  output  5  inst[19:15]
- rr_rs2  output  5  inst[24:20]
- rr_rd  output  5  inst[11:7]
- rr_imm  output  32  sign-extended immediate per format
- rr_opclass  output  10  one-hot: {lui, auipc, jal, jalr, branch, load, store, op_imm, op, system}
- rr_illegal  output  1  opcode not RV32I or inst[1:0] != 2'b11

Behaviour:
- Reset (async, resetn low): tracker valid bits and rr_valid = 0; rr_pc, rr_inst, rr_imm = 0; rr_rs1, rr_rs2, rr_rd = 0; rr_opclass = 0; rr_illegal = 0. Takes effect immediately, mid-operation included.
- Tracker:
  - MEM_LATENCY-deep shift register of {valid, pc}.
  - Each clock: stage 0 <= {mem_rinst, mem_rinst_addr}; stage k <= stage k-1.
  - Oldest stage aligns with inst_rdata in the same cycle.
- Capture:
  - On each edge with no redirect, rr_* <= predecode(inst_rdata) and rr_pc <= oldest.pc.
  - rr_valid <= oldest.valid.
  - rr_* data fields update even when oldest.valid = 0; consumers qualify with rr_valid.
- Latency: request visible in cycle n → rr_valid/rr_* visible in cycle n+MEM_LATENCY+1.
- Redirect: any do_refetch bit = 1 in cycle n. On the edge ending cycle n:
  - All tracker valid bits <= 0, including the request sampled this edge (IF's cycle-n address is wrong-path).
  - rr_valid <= 0. The word on inst_rdata in cycle n is dropped.
  - First correct-path instruction (IF address in cycle n+1) reaches rr_valid in cycle n+MEM_LATENCY+2.
- Back-to-back redirects: each one re-kills; no counter saturation issues since the kill is a bit-clear, not a count.
- Redirect in the same cycle as reset release has no effect (valid bits already 0).
- finish handling: IF drops mem_rinst; in-flight valid entries drain normally and rr_valid falls MEM_LATENCY+1 cycles after the last valid request.
- No stall input. RR consumes every cycle; the load-use hazard is handled by refetch, not back-pressure.
- Predecode (combinational on inst_rdata, registered into rr_*):
  - opcode = inst[6:0].
  - I-type imm = {{20{i[31]}}, i[31:20]}; applies to jalr, load, op_imm, system.
  - S-type imm = {{20{i[31]}}, i[31:25], i[11:7]}.
  - B-type imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - U-type imm = {i[31:12], 12'b0}.
  - J-type imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
  - op class: lui, auipc, op use R/U formats; op has imm = 0.
  - Unknown opcode: rr_opclass = 0, rr_imm = 0, rr_illegal = 1. rr_illegal is qualified by rr_valid.
- rr_rs1/rr_rs2/rr_rd are raw fields regardless of format; downstream ignores unused ones.

Test Plan:
- Straight-line, MEM_LATENCY=1:
  - Stimulus: requests 0x0, 0x4, 0x8 in cycles 1-3; rdata 0x00500093 (addi x1,x0,5) in cycle 2.
  - Required: cycle 3 shows rr_valid=1, rr_pc=0x0, rr_rd=1, rr_imm=5, rr_opclass=op_imm.
- Redirect kill, MEM_LATENCY=2:
  - Stimulus: branch_hit_ex in cycle 10 with requests 0x20 (cycle 9) and 0x24 (cycle 10) in flight.
  - Required: rr_valid=0 in cycles 11-13; first valid rr_pc = IF's cycle-11 address in cycle 14.
- Immediate formats:
  - Stimulus: rdata 0xFE000EE3 (beq, imm −4); 0x800000EF (jal, imm −1048576 = 0xFFF00000); 0xFFF00113 (addi, imm −1).
  - Required: rr_imm = 0xFFFFFFFC, 0xFFF00000, 0xFFFFFFFF respectively.
- Illegal opcode:
  - Stimulus: rdata 0x0000000B.
  - Required: rr_illegal=1, rr_opclass=0, rr_valid=1.
- Reset mid-stream:
  - Stimulus: resetn low for 1 cycle while 2 requests are in flight.
  - Required: rr_valid=0 immediately; no stale PC emerges after release.
- finish drain:
  - Stimulus: mem_rinst drops after request 0x40.
  - Required: 0x40 appears at rr_pc MEM_LATENCY+1 cycles later, then rr_valid stays 0.

Source files
------------

// File: rtl/fetch_return_predecode.sv
// Pairs fixed-latency instruction-memory returns with their fetch PCs, drops
// wrong-path words on any redirect, and registers an RV32I predecode for RR.
module fetch_return_predecode #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_rinst,
  input  logic [31:0] mem_rinst_addr,
  input  logic [31:0] inst_rdata,
  input  logic [2:0]  do_refetch,
  output logic        rr_valid,
  output logic [31:0] rr_pc,
  output logic [31:0] rr_inst,
  output logic [4:0]  rr_rs1,
  output logic [4:0]  rr_rs2,
  output logic [4:0]  rr_rd,
  output logic [31:0] rr_imm,
  output logic [9:0]  rr_opclass,
  output logic        rr_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        r_trk_valid [MEM_LATENCY];
  logic [31:0] r_trk_pc    [MEM_LATENCY];

  logic        r_rr_valid;
  logic [31:0] r_rr_pc;
  logic [31:0] r_rr_inst;
  logic [31:0] r_rr_imm;
  logic [9:0]  r_rr_opclass;
  logic        r_rr_illegal;

  logic        w_redirect;
  logic [6:0]  w_opcode;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic [9:0]  w_opclass;

  assign w_redirect = |do_refetch;

  // A redirect clears every in-flight slot, including the one loaded on this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < MEM_LATENCY; k++) begin
        r_trk_valid[k] <= 1'b0;
        r_trk_pc[k]    <= 32'h0;
      end
    end else begin
      r_trk_valid[0] <= mem_rinst & ~w_redirect;
      r_trk_pc[0]    <= mem_rinst_addr;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        r_trk_valid[k] <= r_trk_valid[k-1] & ~w_redirect;
        r_trk_pc[k]    <= r_trk_pc[k-1];
      end
    end
  end

  assign w_opcode = inst_rdata[6:0];
  assign w_imm_i  = {{20{inst_rdata[31]}}, inst_rdata[31:20]};
  assign w_imm_s  = {{20{inst_rdata[31]}}, inst_rdata[31:25], inst_rdata[11:7]};
  assign w_imm_b  = {{19{inst_rdata[31]}}, inst_rdata[31], inst_rdata[7],
                     inst_rdata[30:25], inst_rdata[11:8], 1'b0};
  assign w_imm_u  = {inst_rdata[31:12], 12'b0};
  assign w_imm_j  = {{11{inst_rdata[31]}}, inst_rdata[31], inst_rdata[19:12],
                     inst_rdata[20], inst_rdata[30:21], 1'b0};

  always_comb begin
    w_opclass = 10'b0;
    w_imm     = 32'h0;
    case (w_opcode)
      OP_LUI:    begin w_opclass = 10'b10_0000_0000; w_imm = w_imm_u; end
      OP_AUIPC:  begin w_opclass = 10'b01_0000_0000; w_imm = w_imm_u; end
      OP_JAL:    begin w_opclass = 10'b00_1000_0000; w_imm = w_imm_j; end
      OP_JALR:   begin w_opclass = 10'b00_0100_0000; w_imm = w_imm_i; end
      OP_BRANCH: begin w_opclass = 10'b00_0010_0000; w_imm = w_imm_b; end
      OP_LOAD:   begin w_opclass = 10'b00_0001_0000; w_imm = w_imm_i; end
      OP_STORE:  begin w_opclass = 10'b00_0000_1000; w_imm = w_imm_s; end
      OP_IMM:    begin w_opclass = 10'b00_0000_0100; w_imm = w_imm_i; end
      OP_OP:     begin w_opclass = 10'b00_0000_0010; w_imm = 32'h0;   end
      OP_SYSTEM: begin w_opclass = 10'b00_0000_0001; w_imm = w_imm_i; end
      default:   begin w_opclass = 10'b0;            w_imm = 32'h0;   end
    endcase
  end

  // Data fields follow memory every non-redirect edge; rr_valid qualifies them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_valid   <= 1'b0;
      r_rr_pc      <= 32'h0;
      r_rr_inst    <= 32'h0;
      r_rr_imm     <= 32'h0;
      r_rr_opclass <= 10'b0;
      r_rr_illegal <= 1'b0;
    end else begin
      r_rr_valid <= r_trk_valid[MEM_LATENCY-1] & ~w_redirect;
      if (!w_redirect) begin
        r_rr_pc      <= r_trk_pc[MEM_LATENCY-1];
        r_rr_inst    <= inst_rdata;
        r_rr_imm     <= w_imm;
        r_rr_opclass <= w_opclass;
        r_rr_illegal <= (w_opclass == 10'b0);
      end
    end
  end

  assign rr_valid   = r_rr_valid;
  assign rr_pc      = r_rr_pc;
  assign rr_inst    = r_rr_inst;
  assign rr_rs1     = r_rr_inst[19:15];
  assign rr_rs2     = r_rr_inst[24:20];
  assign rr_rd      = r_rr_inst[11:7];
  assign rr_imm     = r_rr_imm;
  assign rr_opclass = r_rr_opclass;
  assign rr_illegal = r_rr_illegal;

endmodule

// File: tb/tb_fetch_return_predecode.sv
// Drives three fetch_return_predecode instances (latency 1, 2, 4) from one fetch
// stream and a shared instruction memory, checking each against a cycle-history model.
module tb_fetch_return_predecode;

  localparam int NCYC = 512;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [9:0]  oc;
    logic        ill;
  } pd_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_rinst;
  logic [31:0] mem_rinst_addr;
  logic [2:0]  do_refetch;
  logic [31:0] rdata [3];

  logic        o_valid [3];
  logic [31:0] o_pc    [3];
  logic [31:0] o_inst  [3];
  logic [4:0]  o_rs1   [3];
  logic [4:0]  o_rs2   [3];
  logic [4:0]  o_rd    [3];
  logic [31:0] o_imm   [3];
  logic [9:0]  o_oc    [3];
  logic        o_ill   [3];

  logic [31:0] mem   [64];
  logic        h_v     [NCYC];
  logic [31:0] h_pc    [NCYC];
  logic        h_redir [NCYC];
  logic        h_rst   [NCYC];

  int cyc   = -1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_return_predecode #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .mem_rinst(mem_rinst), .mem_rinst_addr(mem_rinst_addr),
    .inst_rdata(rdata[0]), .do_refetch(do_refetch), .rr_valid(o_valid[0]), .rr_pc(o_pc[0]),
    .rr_inst(o_inst[0]), .rr_rs1(o_rs1[0]), .rr_rs2(o_rs2[0]), .rr_rd(o_rd[0]),
    .rr_imm(o_imm[0]), .rr_opclass(o_oc[0]), .rr_illegal(o_ill[0]));

  fetch_return_predecode #(.MEM_LATENCY(2)) u_l2 (
    .clk(clk), .resetn(resetn), .mem_rinst(mem_rinst), .mem_rinst_addr(mem_rinst_addr),
    .inst_rdata(rdata[1]), .do_refetch(do_refetch), .rr_valid(o_valid[1]), .rr_pc(o_pc[1]),
    .rr_inst(o_inst[1]), .rr_rs1(o_rs1[1]), .rr_rs2(o_rs2[1]), .rr_rd(o_rd[1]),
    .rr_imm(o_imm[1]), .rr_opclass(o_oc[1]), .rr_illegal(o_ill[1]));

  fetch_return_predecode #(.MEM_LATENCY(4)) u_l4 (
    .clk(clk), .resetn(resetn), .mem_rinst(mem_rinst), .mem_rinst_addr(mem_rinst_addr),
    .inst_rdata(rdata[2]), .do_refetch(do_refetch), .rr_valid(o_valid[2]), .rr_pc(o_pc[2]),
    .rr_inst(o_inst[2]), .rr_rs1(o_rs1[2]), .rr_rs2(o_rs2[2]), .rr_rd(o_rd[2]),
    .rr_imm(o_imm[2]), .rr_opclass(o_oc[2]), .rr_illegal(o_ill[2]));

  function automatic int ml_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] memw(input logic [31:0] addr);
    return mem[addr[7:2]];
  endfunction

  // Immediates are rebuilt as signed integers from their bit weights.
  function automatic pd_t pd(input logic [31:0] w);
    pd_t r;
    int  v;
    r      = '0;
    r.inst = w;
    r.rs1  = w[19:15];
    r.rs2  = w[24:20];
    r.rd   = w[11:7];
    v      = 0;
    case (w[6:0])
      7'h37: begin r.oc = 10'h200; v = int'(w[31:12]) * 4096; end
      7'h17: begin r.oc = 10'h100; v = int'(w[31:12]) * 4096; end
      7'h6f: begin
        r.oc = 10'h080;
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12)
          + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2;
        if (w[31]) v = v - (1 << 21);
      end
      7'h67, 7'h03, 7'h13, 7'h73: begin
        r.oc = (w[6:0] == 7'h67) ? 10'h040 : (w[6:0] == 7'h03) ? 10'h010 :
               (w[6:0] == 7'h13) ? 10'h004 : 10'h001;
        v = int'(w[31:20]);
        if (w[31]) v = v - 4096;
      end
      7'h63: begin
        r.oc = 10'h020;
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v = v - 8192;
      end
      7'h23: begin
        r.oc = 10'h008;
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (w[31]) v = v - 4096;
      end
      7'h33: begin r.oc = 10'h002; v = 0; end
      default: begin r.oc = 10'h000; v = 0; r.ill = 1'b1; end
    endcase
    r.imm = 32'(v);
    return r;
  endfunction

  function automatic int clamp0(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  // A request issued in cycle n shows in cycle n+ml+1 unless a redirect or reset hit cycles n..c-1.
  function automatic logic exp_valid(input int ml, input int c);
    int n;
    n = c - ml - 1;
    if (h_rst[c] || n < 0 || !h_v[n]) return 1'b0;
    for (int k = n; k < c; k++)
      if (h_redir[k] || h_rst[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Data fields reflect the memory word of the latest edge that was neither reset nor redirect.
  function automatic pd_t exp_data(input int ml, input int c);
    if (h_rst[c]) return '0;
    for (int e = c - 1; e >= 0; e--) begin
      if (h_rst[e]) return '0;
      if (!h_redir[e]) return pd(memw(h_pc[clamp0(e - ml)]));
    end
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mcheck(input int d);
    int    ml;
    logic  ev;
    pd_t   ed;
    string p;
    ml = ml_of(d);
    ev = exp_valid(ml, cyc);
    ed = exp_data(ml, cyc);
    p  = $sformatf("l%0d_c%0d", ml, cyc);
    chk({p, "_valid"}, 32'(o_valid[d]), 32'(ev));
    if (ev) chk({p, "_pc"}, o_pc[d], h_pc[cyc - ml - 1]);
    chk({p, "_inst"}, o_inst[d], ed.inst);
    chk({p, "_imm"}, o_imm[d], ed.imm);
    chk({p, "_rs1"}, 32'(o_rs1[d]), 32'(ed.rs1));
    chk({p, "_rs2"}, 32'(o_rs2[d]), 32'(ed.rs2));
    chk({p, "_rd"}, 32'(o_rd[d]), 32'(ed.rd));
    chk({p, "_opclass"}, 32'(o_oc[d]), 32'(ed.oc));
    chk({p, "_illegal"}, 32'(o_ill[d]), 32'(ed.ill));
  endtask

  // One cycle: drive inputs just after the edge, then check every instance on the falling edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [2:0] rf, input logic rst);
    @(posedge clk);
    #1;
    cyc++;
    resetn         = ~rst;
    mem_rinst      = v;
    mem_rinst_addr = a;
    do_refetch     = rf;
    h_v[cyc]       = v;
    h_pc[cyc]      = a;
    h_redir[cyc]   = (rf != 3'b000);
    h_rst[cyc]     = rst;
    for (int d = 0; d < 3; d++) rdata[d] = memw(h_pc[clamp0(cyc - ml_of(d))]);
    @(negedge clk);
    for (int d = 0; d < 3; d++) mcheck(d);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          s;
    w = $urandom();
    s = $urandom_range(0, 11);
    case (s)
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6f;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;
      9: w[6:0] = 7'h73;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    logic        v;
    logic [2:0]  rf;
    logic        rst;

    resetn         = 1'b0;
    mem_rinst      = 1'b0;
    mem_rinst_addr = 32'h0;
    do_refetch     = 3'b000;
    for (int d = 0; d < 3; d++) rdata[d] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = rand_inst();
    mem[0] = 32'h00500093;
    mem[3] = 32'hFE000EE3;
    mem[4] = 32'h800000EF;
    mem[5] = 32'hFFF00113;
    mem[6] = 32'h0000000B;

    step(1'b0, 32'h0,  3'b000, 1'b1);
    step(1'b1, 32'h0,  3'b000, 1'b0);
    step(1'b1, 32'h4,  3'b000, 1'b0);
    step(1'b1, 32'h8,  3'b000, 1'b0);
    chk("straight_valid", 32'(o_valid[0]), 32'h1);
    chk("straight_pc", o_pc[0], 32'h0);
    chk("straight_rd", 32'(o_rd[0]), 32'h1);
    chk("straight_imm", o_imm[0], 32'h5);
    chk("straight_opclass", 32'(o_oc[0]), 32'h004);
    step(1'b1, 32'hC,  3'b000, 1'b0);
    step(1'b1, 32'h10, 3'b000, 1'b0);
    step(1'b1, 32'h14, 3'b000, 1'b0);
    chk("imm_beq", o_imm[0], 32'hFFFFFFFC);
    step(1'b1, 32'h18, 3'b000, 1'b0);
    chk("imm_jal", o_imm[0], 32'hFFF00000);
    step(1'b1, 32'h1C, 3'b000, 1'b0);
    chk("imm_addi", o_imm[0], 32'hFFFFFFFF);
    step(1'b1, 32'h20, 3'b000, 1'b0);
    chk("illegal_flag", 32'(o_ill[0]), 32'h1);
    chk("illegal_opclass", 32'(o_oc[0]), 32'h0);
    chk("illegal_valid", 32'(o_valid[0]), 32'h1);
    step(1'b1, 32'h24, 3'b100, 1'b0);
    step(1'b1, 32'h30, 3'b000, 1'b0);
    chk("kill_c11", 32'(o_valid[1]), 32'h0);
    step(1'b1, 32'h34, 3'b000, 1'b0);
    chk("kill_c12", 32'(o_valid[1]), 32'h0);
    step(1'b1, 32'h38, 3'b000, 1'b0);
    chk("kill_c13", 32'(o_valid[1]), 32'h0);
    step(1'b1, 32'h3C, 3'b000, 1'b0);
    chk("refetch_valid", 32'(o_valid[1]), 32'h1);
    chk("refetch_pc", o_pc[1], 32'h30);
    step(1'b1, 32'h8,  3'b000, 1'b0);
    step(1'b1, 32'hC,  3'b000, 1'b0);
    step(1'b1, 32'h10, 3'b000, 1'b1);
    for (int d = 0; d < 3; d++) chk($sformatf("reset_valid_l%0d", ml_of(d)), 32'(o_valid[d]), 32'h0);
    step(1'b1, 32'h40, 3'b000, 1'b0);
    step(1'b0, 32'h44, 3'b000, 1'b0);
    step(1'b0, 32'h48, 3'b000, 1'b0);
    chk("drain_l1_valid", 32'(o_valid[0]), 32'h1);
    chk("drain_l1_pc", o_pc[0], 32'h40);
    step(1'b0, 32'h4C, 3'b000, 1'b0);
    chk("drain_l2_pc", o_pc[1], 32'h40);
    chk("drain_l1_after", 32'(o_valid[0]), 32'h0);
    step(1'b0, 32'h50, 3'b000, 1'b0);
    step(1'b0, 32'h54, 3'b000, 1'b0);
    chk("drain_l4_valid", 32'(o_valid[2]), 32'h1);
    chk("drain_l4_pc", o_pc[2], 32'h40);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h58, 3'b000, 1'b0);
    chk("drain_l4_after", 32'(o_valid[2]), 32'h0);

    pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 9) < 8);
      rf  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) pc = $urandom() & 32'hFFFF_FFFC;
      else pc = pc + 32'h4;
      step(v, pc, rf, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
